// File: rtl/semafor_pkg.sv
// Shared types and defaults for the multi-approach traffic-light controller.
package semafor_pkg;

    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2,
        FLASH   = 2'd3
    } state_e;

    localparam int T_GREEN_DEF  = 20;
    localparam int T_YELLOW_DEF = 3;
    localparam int T_ALLRED_DEF = 2;

    // Width of an approach index; never narrower than one bit.
    function automatic int dir_width(input int n_dir);
        return (n_dir > 1) ? $clog2(n_dir) : 1;
    endfunction

endpackage

// File: rtl/semafor_rr_arb.sv
// Combinational round-robin finder: first requesting approach after cur,
// cur itself last; with no demand it falls back to cur+1.
module semafor_rr_arb
    import semafor_pkg::*;
#(
    parameter  int N_DIR = 4,
    localparam int DIR_W = dir_width(N_DIR)
) (
    input  logic [N_DIR-1:0] req,
    input  logic [DIR_W-1:0] cur,
    output logic [DIR_W-1:0] nxt
);

    always_comb begin
        int               idx;
        logic             found;
        logic [DIR_W-1:0] sel;
        found = 1'b0;
        idx   = (int'(cur) + 1) % N_DIR;
        sel   = DIR_W'(idx);
        nxt   = sel;
        for (int i = 1; i <= N_DIR; i++) begin
            idx = (int'(cur) + i) % N_DIR;
            sel = DIR_W'(idx);
            if (!found && req[sel]) begin
                nxt   = sel;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/semafor_ctrl_multi.sv
// Traffic-light phase controller: one green approach at a time, round-robin
// on demand, with green extension, emergency all-red and flashing yellow.
module semafor_ctrl_multi
    import semafor_pkg::*;
#(
    parameter  int N_DIR    = 4,
    parameter  int CNT_W    = 8,
    parameter  int T_GREEN  = T_GREEN_DEF,
    parameter  int T_YELLOW = T_YELLOW_DEF,
    parameter  int T_ALLRED = T_ALLRED_DEF,
    localparam int DIR_W    = dir_width(N_DIR)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             tick_i,
    input  logic             enable_i,
    input  logic             emerg_i,
    input  logic [N_DIR-1:0] req_i,
    output logic [N_DIR-1:0] rosu_o,
    output logic [N_DIR-1:0] galben_o,
    output logic [N_DIR-1:0] verde_o,
    output logic [DIR_W-1:0] dir_o
);

    localparam int T_MAX = (1 << CNT_W) - 1;

    if (N_DIR < 2 || N_DIR > 8) begin : g_bad_n_dir
        $error("N_DIR must be within 2..8");
    end
    if (T_GREEN < 1 || T_GREEN > T_MAX || T_YELLOW < 1 || T_YELLOW > T_MAX ||
        T_ALLRED < 1 || T_ALLRED > T_MAX) begin : g_bad_durations
        $error("phase durations must be within 1..2^CNT_W-1");
    end

    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(T_ALLRED - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [DIR_W-1:0] dir_q, dir_d;
    logic             blink_q, blink_d;

    logic [DIR_W-1:0] arb_nxt;
    logic [N_DIR-1:0] dir_oh;
    logic [CNT_W-1:0] timer_dec;
    logic             expiry;
    logic             other_req;

    semafor_rr_arb #(.N_DIR(N_DIR)) u_arb (
        .req (req_i),
        .cur (dir_q),
        .nxt (arb_nxt)
    );

    assign dir_oh    = {{(N_DIR-1){1'b0}}, 1'b1} << dir_q;
    assign other_req = |(req_i & ~dir_oh);
    assign expiry    = (timer_q == '0) && tick_i;
    // Saturates at zero, which is what holds an extended green.
    assign timer_dec = (tick_i && timer_q != '0) ? timer_q - 1'b1 : timer_q;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d = state_q;
        timer_d = timer_dec;
        dir_d   = dir_q;
        blink_d = blink_q;
        if (!enable_i) begin
            timer_d = timer_q;
            if (state_q == FLASH) begin
                blink_d = blink_q ^ tick_i;
            end else begin
                state_d = FLASH;
                blink_d = 1'b0;
            end
        end else begin
            case (state_q)
                ALL_RED: begin
                    if (emerg_i) begin
                        timer_d = ALLRED_LD;
                    end else if (expiry) begin
                        state_d = GREEN;
                        dir_d   = arb_nxt;
                        timer_d = GREEN_LD;
                    end
                end
                GREEN: begin
                    if (emerg_i || (expiry && other_req)) begin
                        state_d = YELLOW;
                        timer_d = YELLOW_LD;
                    end
                end
                YELLOW: begin
                    if (expiry) begin
                        state_d = ALL_RED;
                        timer_d = ALLRED_LD;
                    end
                end
                default: begin
                    state_d = ALL_RED;
                    timer_d = ALLRED_LD;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n_i) begin
            state_q <= ALL_RED;
            timer_q <= ALLRED_LD;
            dir_q   <= '0;
            blink_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            dir_q   <= dir_d;
            blink_q <= blink_d;
        end
    end

    always_comb begin
        rosu_o   = '0;
        galben_o = '0;
        verde_o  = '0;
        case (state_q)
            GREEN: begin
                verde_o = dir_oh;
                rosu_o  = ~dir_oh;
            end
            YELLOW: begin
                galben_o = dir_oh;
                rosu_o   = ~dir_oh;
            end
            FLASH:   galben_o = {N_DIR{blink_q}};
            default: rosu_o = '1;
        endcase
    end

    assign dir_o = dir_q;

endmodule

// File: tb/tb_semafor_ctrl_multi.sv
// Directed bench for semafor_ctrl_multi: a 4-approach instance for phase
// timing, emergency, flash and async reset, and a 3-approach wrap-around.
module tb_semafor_ctrl_multi;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rst3_n;
    logic       tick;
    logic       en;
    logic       emerg;
    logic [3:0] req4;
    logic [3:0] rosu4, galben4, verde4;
    logic [1:0] dir4;
    logic [2:0] req3;
    logic [2:0] rosu3, galben3, verde3;
    logic [1:0] dir3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    semafor_ctrl_multi #(.N_DIR(4)) dut4 (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .tick_i   (tick),
        .enable_i (en),
        .emerg_i  (emerg),
        .req_i    (req4),
        .rosu_o   (rosu4),
        .galben_o (galben4),
        .verde_o  (verde4),
        .dir_o    (dir4)
    );

    semafor_ctrl_multi #(.N_DIR(3)) dut3 (
        .clk_i    (clk),
        .rst_n_i  (rst3_n),
        .tick_i   (tick),
        .enable_i (en),
        .emerg_i  (emerg),
        .req_i    (req3),
        .rosu_o   (rosu3),
        .galben_o (galben3),
        .verde_o  (verde3),
        .dir_o    (dir3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Packed as {dir, rosu, galben, verde}.
    task automatic lamps4(input string tag, input logic [3:0] er, input logic [3:0] ey,
                          input logic [3:0] eg, input logic [1:0] ed);
        check(tag, {18'd0, dir4, rosu4, galben4, verde4}, {18'd0, ed, er, ey, eg});
    endtask

    task automatic lamps3(input string tag, input logic [2:0] er, input logic [2:0] ey,
                          input logic [2:0] eg, input logic [1:0] ed);
        check(tag, {21'd0, dir3, rosu3, galben3, verde3}, {21'd0, ed, er, ey, eg});
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        check("onehot_g4", {31'd0, $onehot0(verde4)}, 32'd1);
        check("onehot_g3", {31'd0, $onehot0(verde3)}, 32'd1);
    end

    initial begin
        rst_n  = 1'b0;
        rst3_n = 1'b0;
        tick   = 1'b0;
        en     = 1'b1;
        emerg  = 1'b0;
        req4   = 4'b0000;
        req3   = 3'b000;
        run(3);
        lamps4("reset", 4'hF, 4'h0, 4'h0, 2'd0);
        rst_n = 1'b1;

        // Without ticks the all-red timer must not advance.
        run(3);
        lamps4("no_tick", 4'hF, 4'h0, 4'h0, 2'd0);

        tick = 1'b1;
        run(1); lamps4("ar_tick1", 4'hF, 4'h0, 4'h0, 2'd0);
        run(1); lamps4("g1_enter", 4'hD, 4'h0, 4'h2, 2'd1);
        run(19); lamps4("g1_tick19", 4'hD, 4'h0, 4'h2, 2'd1);
        run(1); lamps4("g1_extend", 4'hD, 4'h0, 4'h2, 2'd1);
        run(30); lamps4("g1_ext_long", 4'hD, 4'h0, 4'h2, 2'd1);

        // Demand on another approach ends the extension at the next tick.
        req4 = 4'b1010;
        run(1); lamps4("y1_enter", 4'hD, 4'h2, 4'h0, 2'd1);
        run(2); lamps4("y1_tick3", 4'hD, 4'h2, 4'h0, 2'd1);
        run(1); lamps4("ar_after_y1", 4'hF, 4'h0, 4'h0, 2'd1);
        run(1); lamps4("ar_tick2", 4'hF, 4'h0, 4'h0, 2'd1);
        run(1); lamps4("g3_enter", 4'h7, 4'h0, 4'h8, 2'd3);
        run(19); lamps4("g3_tick19", 4'h7, 4'h0, 4'h8, 2'd3);
        run(1); lamps4("y3_enter", 4'h7, 4'h8, 4'h0, 2'd3);
        run(2); lamps4("y3_tick3", 4'h7, 4'h8, 4'h0, 2'd3);
        run(1); lamps4("ar_after_y3", 4'hF, 4'h0, 4'h0, 2'd3);
        run(2); lamps4("g1_again", 4'hD, 4'h0, 4'h2, 2'd1);

        // Emergency during green, held through the all-red phase.
        run(5);
        emerg = 1'b1;
        run(1); lamps4("em_yellow", 4'hD, 4'h2, 4'h0, 2'd1);
        run(2); lamps4("em_y_tick3", 4'hD, 4'h2, 4'h0, 2'd1);
        run(1); lamps4("em_allred", 4'hF, 4'h0, 4'h0, 2'd1);
        run(6); lamps4("em_hold", 4'hF, 4'h0, 4'h0, 2'd1);
        emerg = 1'b0;
        run(1); lamps4("em_clear1", 4'hF, 4'h0, 4'h0, 2'd1);
        run(1); lamps4("em_grant", 4'h7, 4'h0, 4'h8, 2'd3);

        // Flashing yellow; the entry tick must not toggle blink.
        run(3);
        en = 1'b0;
        run(1); lamps4("fl_enter", 4'h0, 4'h0, 4'h0, 2'd3);
        run(1); lamps4("fl_on", 4'h0, 4'hF, 4'h0, 2'd3);
        run(1); lamps4("fl_off", 4'h0, 4'h0, 4'h0, 2'd3);
        tick = 1'b0;
        run(2); lamps4("fl_no_tick", 4'h0, 4'h0, 4'h0, 2'd3);
        tick = 1'b1;
        run(1); lamps4("fl_on2", 4'h0, 4'hF, 4'h0, 2'd3);
        en = 1'b1;
        run(1); lamps4("fl_exit", 4'hF, 4'h0, 4'h0, 2'd3);
        run(1); lamps4("fl_exit_t1", 4'hF, 4'h0, 4'h0, 2'd3);
        run(1); lamps4("fl_grant", 4'hD, 4'h0, 4'h2, 2'd1);

        // Asynchronous reset in the middle of yellow, released between edges.
        run(20); lamps4("pre_rst_y", 4'hD, 4'h2, 4'h0, 2'd1);
        run(1);
        #2;
        rst_n = 1'b0;
        #1;
        lamps4("arst_assert", 4'hF, 4'h0, 4'h0, 2'd0);
        rst_n = 1'b1;
        #1;
        lamps4("arst_release", 4'hF, 4'h0, 4'h0, 2'd0);
        run(1); lamps4("rst_ar1", 4'hF, 4'h0, 4'h0, 2'd0);
        run(1); lamps4("rst_grant", 4'hD, 4'h0, 4'h2, 2'd1);

        // Three-approach build: grant wraps from dir 2 back to dir 0.
        req3   = 3'b100;
        rst3_n = 1'b1;
        run(1); lamps3("n3_ar", 3'b111, 3'b000, 3'b000, 2'd0);
        run(1); lamps3("n3_g2", 3'b011, 3'b000, 3'b100, 2'd2);
        req3 = 3'b001;
        run(19); lamps3("n3_g2_t19", 3'b011, 3'b000, 3'b100, 2'd2);
        run(1); lamps3("n3_y2", 3'b011, 3'b100, 3'b000, 2'd2);
        run(3); lamps3("n3_ar2", 3'b111, 3'b000, 3'b000, 2'd2);
        run(2); lamps3("n3_wrap", 3'b110, 3'b000, 3'b001, 2'd0);

        run(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/semafor_ctrl_multi.md
# semafor_ctrl_multi

Parametrised multi-approach traffic-light phase controller for the intersection top level. It drives red/yellow/green lamps for N_DIR approaches. Green is granted to one approach at a time under round-robin arbitration of vehicle demand, with programmable green, yellow and all-red durations counted in timebase ticks. The block adds green extension, an emergency all-red override and a flashing-yellow mode when disabled.

## Interface
- N_DIR, 4: number of approaches, 2..8
- CNT_W, 8: phase timer width
- T_GREEN, 20: minimum green duration in ticks, 1..2^CNT_W-1
- T_YELLOW, 3: yellow duration in ticks, same range
- T_ALLRED, 2: all-red clearance in ticks, same range
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- tick_i  in  1  timebase strobe, one clk_i cycle wide
- enable_i  in  1  1 = normal operation, 0 = flashing yellow
- emerg_i  in  1  level; 1 = force all approaches to red
- req_i  in  N_DIR  per-approach vehicle demand, level
- rosu_o  out  N_DIR  red lamp per approach
- galben_o  out  N_DIR  yellow lamp per approach
- verde_o  out  N_DIR  green lamp per approach
- dir_o  out  max(1,$clog2(N_DIR))  approach currently owning the phase

## Operation
- States: ALL_RED, GREEN, YELLOW, FLASH. Reset values: state ALL_RED, dir 0, timer T_ALLRED-1, blink 0. After reset rosu_o is all ones, galben_o and verde_o are 0, and dir_o is 0.
- Lamp decode:
  - GREEN: verde_o[dir]=1; all other approaches red.
  - YELLOW: galben_o[dir]=1; all other approaches red.
  - ALL_RED: all red.
  - FLASH: galben_o is all bits = blink; rosu_o and verde_o are 0.
- Timer: on state entry it loads T_x-1. It decrements on tick_i while nonzero. Expiry means timer==0 && tick_i.
- Priority, evaluated every clk_i: !enable_i > emerg_i > timer.
- Normal transitions:
  - ALL_RED, expiry, emerg_i=0 → GREEN. dir takes the arbiter result.
  - GREEN, expiry, some req_i[k]=1 with k≠dir → YELLOW.
  - GREEN, expiry, no other request → stay GREEN (extension). Timer holds at 0; the next tick with another request moves to YELLOW.
  - YELLOW, expiry → ALL_RED.
- Arbiter: searches dir+1, dir+2, … wrapping, dir itself last, and picks the first k with req_i[k]=1. If no request, it picks (dir+1) mod N_DIR (fixed rotation).
- Emergency:
  - emerg_i=1 in GREEN → YELLOW immediately, timer loads T_YELLOW-1. YELLOW then completes normally.
  - In ALL_RED, the state is held and the timer reloads T_ALLRED-1 while emerg_i=1. After release, a full T_ALLRED clearance runs.
- Disable:
  - enable_i=0 from any state → FLASH on the next clk_i. blink clears on entry and toggles on each tick_i.
  - enable_i=1 in FLASH → ALL_RED with T_ALLRED-1 loaded. dir is unchanged.

## Timing
- State, timer, dir and blink are registered.
- Lamp outputs and dir_o are combinational decodes of registered state only, so they change in the cycle after the deciding edge. There is no input→output combinational path.
- Durations:
  - GREEN lasts exactly T_GREEN ticks when demand is waiting.
  - YELLOW lasts exactly T_YELLOW ticks.
  - ALL_RED lasts exactly T_ALLRED ticks.
- Each lamp output is one-hot or zero per approach. verde_o is never nonzero on more than one bit.
- Reset asserted mid-phase forces ALL_RED at once, asynchronously.
- tick_i and a state-forcing input in the same cycle: the forcing input wins. The tick is not carried into the new state.

## Structure
- Package semafor_pkg holds:
  - the state enum (ALL_RED, GREEN, YELLOW, FLASH);
  - the default durations;
  - a function computing the dir width from N_DIR.
- Sub-module semafor_rr_arb: combinational round-robin next-index finder with parameter N_DIR and ports req, cur → nxt. It is instantiated once.
- The top level holds the FSM, timer and decode. Parameter range checks are elaboration-time assertions.

## Test plan
- Reset, then all req_i=0 with tick_i every cycle → ALL_RED for 2 ticks, then dir 1 green for 20 ticks. With no demand, dir 1 stays green (extension) indefinitely.
- req_i=4'b1010, dir 1 green → after 20 ticks, 3 ticks yellow on dir 1, 2 ticks all-red, then dir 3 green. Next grant is dir 1 again.
- emerg_i pulse at green tick 5 → yellow starts the next cycle for 3 ticks, all-red held while emerg_i=1, then 2 more ticks all-red, then arbitration.
- enable_i=0 during GREEN → next cycle, all galben_o toggle on each tick with rosu_o=verde_o=0. enable_i=1 → all red for 2 ticks, then arbitration from the held dir.
- rst_n_i asserted mid-yellow, deasserted with no clock → outputs immediately all red and dir_o=0.
- N_DIR=3 build with req_i=3'b001, dir 2 → wrap-around grants dir 0. verde_o is checked for at most one bit set every cycle.
